// File: rtl/freq_divider_pkg.sv
// Shared width constants for the pulse-rate divider.
package freq_divider_pkg;

    localparam int unsigned BYTE_BITS = 8;

endpackage : freq_divider_pkg

// File: rtl/freq_divider.sv
// Programmable pulse-rate divider: one-clk strobe on out every div qualified ticks.
module freq_divider
    import freq_divider_pkg::*;
#(
    parameter int unsigned DIV_BITS = BYTE_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                en,
    input  logic [DIV_BITS-1:0] div,
    output logic                out
);

    logic [DIV_BITS-1:0] cnt;

    // Counter and registered strobe; div-1 is only formed when div is non-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (!clk_en) begin
            out <= 1'b0;
        end else if (div == '0) begin
            cnt <= '0;
            out <= 1'b0;
        end else if (cnt >= (div - DIV_BITS'(1))) begin
            cnt <= '0;
            out <= 1'b1;
        end else begin
            cnt <= cnt + DIV_BITS'(1);
            out <= 1'b0;
        end
    end

endmodule : freq_divider

// File: tb/tb_freq_divider.sv
// Self-checking bench for freq_divider: directed patterns plus randomized run vs. a tick-count model.
module tb_freq_divider;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         clk_en;
    logic         en;
    logic [W-1:0] div;
    logic         out;

    int n_checks = 0;
    int n_fail   = 0;

    // model: qualified ticks elapsed in the current period, and expected strobe
    int   prog    = 0;
    logic exp_out = 1'b0;

    freq_divider #(.DIV_BITS(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .en     (en),
        .div    (div),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Behavioural model: a strobe is due once div qualified ticks have elapsed since the period start.
    always begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            prog    = 0;
            exp_out = 1'b0;
        end else if (!en) begin
            prog    = 0;
            exp_out = 1'b0;
        end else if (!clk_en) begin
            exp_out = 1'b0;
        end else if (div == 0) begin
            prog    = 0;
            exp_out = 1'b0;
        end else begin
            prog = prog + 1;
            if (prog >= int'(div)) begin
                prog    = 0;
                exp_out = 1'b1;
            end else begin
                exp_out = 1'b0;
            end
        end
        #1;
        n_checks++;
        if (out !== exp_out) begin
            n_fail++;
            $display("FAIL model_cmp @%0t: out=%b expected=%b (div=%0d en=%b clk_en=%b)",
                     $time, out, exp_out, div, en, clk_en);
        end
    end

    // Record out just after each of n rising edges, bit i = edge i+1.
    task automatic capture(input int n, output logic [31:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            v[i] = out;
        end
    endtask

    logic [31:0] v;
    int          strobes;
    logic        in_reset;

    initial begin
        reset  = 1'b0;
        en     = 1'b0;
        div    = '0;
        clk_en = 1'b1;

        // 1: held in reset, then enabled with ratio 0
        capture(2, v);
        check_vec("reset_hold", v, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        en    = 1'b1;
        capture(4, v);
        check_vec("div0_off", v, 32'd0);

        // 2: div=3 -> 0,0,1 repeating
        @(negedge clk);
        div = W'(3);
        capture(10, v);
        check_vec("div3_pattern", v, 32'b0100100100);

        // 3: switch to 5 with one tick of progress -> strobe after 4 more ticks, then period 5
        @(negedge clk);
        div = W'(5);
        capture(9, v);
        check_vec("div3to5_switch", v, 32'b100001000);

        // 4: disable clears, re-enable restarts a full period
        @(negedge clk);
        en = 1'b0;
        capture(4, v);
        check_vec("en_off", v, 32'd0);
        @(negedge clk);
        en = 1'b1;
        capture(10, v);
        check_vec("reenable_div5", v, 32'b1000010000);

        // 5: div=4 with clk_en alternating -> strobe every 8 clk, one clk wide
        @(negedge clk);
        div = W'(4);
        v   = '0;
        for (int i = 0; i < 16; i++) begin
            clk_en = (i % 2 == 0);
            @(posedge clk);
            #1;
            v[i] = out;
            @(negedge clk);
        end
        check_vec("div4_clk_en_toggle", v, 32'b0100000001000000);
        clk_en = 1'b1;
        div    = W'(1);
        capture(6, v);
        check_vec("div1_continuous", v, 32'b111111);

        // 6: async reset between edges at cnt=2, then period restarts
        @(negedge clk);
        div = W'(4);
        capture(2, v);
        check_vec("pre_reset", v, 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_vec("async_reset_cnt2", 32'(out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        capture(8, v);
        check_vec("post_reset_div4", v, 32'b10001000);
        check_vec("strobe_before_reset", 32'(out), 32'd1);
        #2 reset = 1'b0;
        #1 check_vec("async_reset_clears_strobe", 32'(out), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // maximum ratio: first strobe on the 255th tick
        div     = W'(255);
        strobes = 0;
        for (int i = 0; i < 254; i++) begin
            @(posedge clk);
            #1;
            if (out) strobes++;
        end
        check_vec("div255_quiet", 32'(strobes), 32'd0);
        capture(1, v);
        check_vec("div255_terminal", v, 32'd1);

        // randomized run, checked every cycle by the model
        in_reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (in_reset) begin
                reset    = 1'b1;
                in_reset = 1'b0;
            end
            en     = ($urandom_range(0, 15) != 0);
            clk_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 15) == 0) div = W'($urandom_range(0, 255));
                else                            div = W'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                in_reset = 1'b1;
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_freq_divider
